// File: rtl/mux8x1_pkg.sv
// Shared types and helpers for the 8-requester round-robin mux arbiter.
package mux8x1_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {IDLE, GRANT} state_t;

  function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set bit of (req & ~mask) at or after ptr.
module rr_pick8
  import mux8x1_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0] eff;
  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;

  always_comb begin
    eff = req & ~mask;
    // Rotate so ptr lands at bit 0, encode lowest set bit, then rotate the index back.
    rot = N_REQ'({eff, eff} >> ptr);
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    found = |eff;
    idx   = off + ptr;
  end

endmodule

// File: rtl/mux8x1_rr_arbiter.sv
// Round-robin arbiter with a fair hold limit driving one shared 8:1 single-bit mux.
module mux8x1_rr_arbiter
  import mux8x1_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] in,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] sel,
  output logic             result
);

  localparam logic [7:0] HOLD_SAT  = 8'(MAX_HOLD);
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;

  logic [N_REQ-1:0] owner_oh, pick_mask;
  logic             pick_found, others, preempt, mux_bit;
  logic [SEL_W-1:0] pick_idx;

  assign owner_oh  = onehot8(sel_q);
  // The owner never competes against itself on a release or preempt edge.
  assign pick_mask = (state_q == GRANT) ? owner_oh : '0;
  assign others    = |(req & ~owner_oh);
  // Compare with >= so a saturated lone owner still yields once someone else asks.
  assign preempt   = (MAX_HOLD != 0) && (hold_cnt_q >= HOLD_LAST) && others;

  rr_pick8 u_pick (
    .req   (req),
    .mask  (pick_mask),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    if (state_q == IDLE || !req[sel_q] || preempt) begin
      if (pick_found) begin
        state_d    = GRANT;
        gnt_d      = onehot8(pick_idx);
        sel_d      = pick_idx;
        ptr_d      = pick_idx + SEL_W'(1);
        hold_cnt_d = '0;
      end else begin
        state_d    = IDLE;
        gnt_d      = '0;
        hold_cnt_d = '0;
      end
    end else if (hold_cnt_q != HOLD_SAT) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    case (sel_q)
      3'd0:    mux_bit = in[0];
      3'd1:    mux_bit = in[1];
      3'd2:    mux_bit = in[2];
      3'd3:    mux_bit = in[3];
      3'd4:    mux_bit = in[4];
      3'd5:    mux_bit = in[5];
      3'd6:    mux_bit = in[6];
      default: mux_bit = in[7];
    endcase
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign sel       = sel_q;
  assign result    = gnt_valid & mux_bit;

endmodule

// File: tb/tb_mux8x1_rr_arbiter.sv
// Vector-table and scoreboard bench for mux8x1_rr_arbiter (MAX_HOLD 16 and 4 instances).
module tb_mux8x1_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] din = '0;

  logic [7:0] gnt_a, gnt_b;
  logic       gv_a, gv_b, res_a, res_b;
  logic [2:0] sel_a, sel_b;

  always #5 clk = ~clk;

  mux8x1_rr_arbiter #(.MAX_HOLD(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .in(din),
    .gnt(gnt_a), .gnt_valid(gv_a), .sel(sel_a), .result(res_a)
  );

  mux8x1_rr_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .in(din),
    .gnt(gnt_b), .gnt_valid(gv_b), .sel(sel_b), .result(res_b)
  );

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] din;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       res;
  } vec_t;

  typedef struct {
    string      name;
    int         which;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       res;
  } exp_t;

  vec_t vecs[20];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle, queue the expectation, compare after the edge.
  task automatic cyc(input logic r, input logic [7:0] q, input logic [7:0] d, input int w,
                     input logic [7:0] eg, input logic [2:0] es, input logic er, input string nm);
    exp_t e;
    logic [7:0] g;
    logic [2:0] s;
    logic v, o;
    rst_n = r; req = q; din = d;
    e.name = nm; e.which = w; e.gnt = eg; e.sel = es; e.res = er;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    if (e.which == 0) begin g = gnt_a; s = sel_a; v = gv_a; o = res_a; end
    else              begin g = gnt_b; s = sel_b; v = gv_b; o = res_b; end
    chk({e.name, ".gnt"},   g, e.gnt);
    chk({e.name, ".sel"},   {5'd0, s}, {5'd0, e.sel});
    chk({e.name, ".valid"}, {7'd0, v}, {7'd0, (e.gnt != 8'h00)});
    chk({e.name, ".result"},{7'd0, o}, {7'd0, e.res});
  endtask

  initial begin
    logic [7:0] eg;
    vecs[0]  = '{1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0};
    vecs[1]  = '{1'b1, 8'h00, 8'hFF, 8'h00, 3'd0, 1'b0};
    vecs[2]  = '{1'b1, 8'h00, 8'hFF, 8'h00, 3'd0, 1'b0};
    vecs[3]  = '{1'b1, 8'h00, 8'hFF, 8'h00, 3'd0, 1'b0};
    vecs[4]  = '{1'b1, 8'h00, 8'hFF, 8'h00, 3'd0, 1'b0};
    vecs[5]  = '{1'b1, 8'h00, 8'hFF, 8'h00, 3'd0, 1'b0};
    vecs[6]  = '{1'b1, 8'h11, 8'h00, 8'h01, 3'd0, 1'b0};
    vecs[7]  = '{1'b1, 8'h11, 8'h01, 8'h01, 3'd0, 1'b1};
    vecs[8]  = '{1'b1, 8'h10, 8'h01, 8'h10, 3'd4, 1'b0};
    vecs[9]  = '{1'b1, 8'h10, 8'h10, 8'h10, 3'd4, 1'b1};
    vecs[10] = '{1'b1, 8'h00, 8'h10, 8'h00, 3'd4, 1'b0};
    vecs[11] = '{1'b1, 8'h00, 8'hFF, 8'h00, 3'd4, 1'b0};
    vecs[12] = '{1'b1, 8'h20, 8'h20, 8'h20, 3'd5, 1'b1};
    vecs[13] = '{1'b1, 8'h04, 8'h00, 8'h04, 3'd2, 1'b0};
    vecs[14] = '{1'b0, 8'hFF, 8'hFF, 8'h00, 3'd0, 1'b0};
    vecs[15] = '{1'b1, 8'hFF, 8'h00, 8'h01, 3'd0, 1'b0};
    vecs[16] = '{1'b1, 8'hFF, 8'h01, 8'h01, 3'd0, 1'b1};
    vecs[17] = '{1'b1, 8'hFE, 8'h00, 8'h02, 3'd1, 1'b0};
    vecs[18] = '{1'b1, 8'h01, 8'h00, 8'h01, 3'd0, 1'b0};
    vecs[19] = '{1'b1, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0};

    for (int i = 0; i < 20; i++) begin
      cyc(vecs[i].rst_n, vecs[i].req, vecs[i].din, 0,
          vecs[i].gnt, vecs[i].sel, vecs[i].res, $sformatf("vec%0d", i));
      // With sel=5 granted, result must track in[5] combinationally and ignore other bits.
      if (i == 12) begin
        din = 8'h00; #1; chk("comb.in5_low",  {7'd0, res_a}, 8'h00);
        din = 8'hDF; #1; chk("comb.others",   {7'd0, res_a}, 8'h00);
        din = 8'h20; #1; chk("comb.in5_high", {7'd0, res_a}, 8'h01);
        din = 8'hFF; #1; chk("comb.all_high", {7'd0, res_a}, 8'h01);
      end
    end

    // Fair hold limit on the MAX_HOLD=4 instance: 4 cycles each, alternating.
    cyc(1'b0, 8'h00, 8'h00, 1, 8'h00, 3'd0, 1'b0, "hold.rst");
    for (int k = 0; k < 20; k++) begin
      eg = (((k / 4) % 2) == 0) ? 8'h01 : 8'h02;
      cyc(1'b1, 8'h03, 8'h02, 1, eg, (eg == 8'h02) ? 3'd1 : 3'd0, (eg == 8'h02),
          $sformatf("hold%0d", k));
    end

    // Lone requester on the MAX_HOLD=16 instance is never preempted.
    cyc(1'b0, 8'h00, 8'h00, 0, 8'h00, 3'd0, 1'b0, "lone.rst");
    for (int k = 0; k < 40; k++)
      cyc(1'b1, 8'h80, 8'h80, 0, 8'h80, 3'd7, 1'b1, $sformatf("lone%0d", k));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
